// File: rtl/pool1_ctrl.sv
// 2x2 stride-2 signed max-pool sequencer: streams the 28x28 f2 map once,
// reduces each window to its maximum and writes the 14x14 result into f3.
module pool1_ctrl #(
    parameter int DW     = 16,
    parameter int RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pool1_start,
    output logic [9:0]           f2_raddr,
    input  logic signed [DW-1:0] f2_rdata,
    output logic [7:0]           f3_waddr,
    output logic signed [DW-1:0] f3_wdata,
    output logic                 f3_wr_en,
    output logic                 pool1_done,
    output logic                 pool1_busy
);

    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_RUN   = 4'b0010;
    localparam logic [3:0] S_DRAIN = 4'b0100;
    localparam logic [3:0] S_DONE  = 4'b1000;
    localparam int         DCW     = $clog2(RD_LAT + 2) + 1;

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] acc,
                                                  input logic signed [DW-1:0] x);
        return (x > acc) ? x : acc;
    endfunction

    logic [3:0]     state, state_nxt;
    logic           c0, c1;
    logic [3:0]     c2, c3;
    logic           rd_all, issue, at_end;
    logic [DCW-1:0] dcnt;
    logic           vld_p0, first_p0, last_p0, end_p0, end_p1;
    logic [7:0]     wa_p0;
    logic           vld_pl   [1:RD_LAT];
    logic           first_pl [1:RD_LAT];
    logic           last_pl  [1:RD_LAT];
    logic [7:0]     wa_pl    [1:RD_LAT];
    logic signed [DW-1:0] acc_p;

    // Reads stop after the 784th address; the FSM stays in RUN until that read's tag clears end_p1.
    assign issue  = (state == S_RUN) && !rd_all;
    assign at_end = c0 && c1 && (c2 == 4'd13) && (c3 == 4'd13);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pool1_start) state_nxt = S_RUN;
            S_RUN:   if (end_p1) state_nxt = S_DRAIN;
            S_DRAIN: if (dcnt == DCW'(RD_LAT + 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pool1_busy = (state != S_IDLE);
        pool1_done = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0     <= 1'b0;
            c1     <= 1'b0;
            c2     <= '0;
            c3     <= '0;
            rd_all <= 1'b0;
            dcnt   <= '0;
        end else begin
            if (issue) begin
                c0 <= ~c0;
                if (c0) c1 <= ~c1;
                if (c0 && c1) c2 <= (c2 == 4'd13) ? 4'd0 : c2 + 4'd1;
                if (c0 && c1 && c2 == 4'd13) c3 <= (c3 == 4'd13) ? 4'd0 : c3 + 4'd1;
            end
            if (state == S_IDLE) rd_all <= 1'b0;
            else if (issue && at_end) rd_all <= 1'b1;
            dcnt <= (state == S_DRAIN) ? dcnt + DCW'(1) : '0;
        end
    end

    // p0: registered read address plus the window tag for this element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f2_raddr <= '0;
            vld_p0   <= 1'b0;
            first_p0 <= 1'b0;
            last_p0  <= 1'b0;
            end_p0   <= 1'b0;
            end_p1   <= 1'b0;
            wa_p0    <= '0;
        end else begin
            f2_raddr <= issue ? 10'({c3, c1}) * 10'd28 + 10'({c2, c0}) : 10'd0;
            vld_p0   <= issue;
            first_p0 <= issue && !c0 && !c1;
            last_p0  <= issue && c0 && c1;
            end_p0   <= issue && at_end;
            end_p1   <= end_p0;
            wa_p0    <= issue ? 8'(c3) * 8'd14 + 8'(c2) : 8'd0;
        end
    end

    // p1..pRD_LAT: tag rides alongside the RAM access, aligned with f2_rdata at the last stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_pl[i]   <= 1'b0;
                first_pl[i] <= 1'b0;
                last_pl[i]  <= 1'b0;
                wa_pl[i]    <= '0;
            end
        end else begin
            vld_pl[1]   <= vld_p0;
            first_pl[1] <= first_p0;
            last_pl[1]  <= last_p0;
            wa_pl[1]    <= wa_p0;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pl[i]   <= vld_pl[i-1];
                first_pl[i] <= first_pl[i-1];
                last_pl[i]  <= last_pl[i-1];
                wa_pl[i]    <= wa_pl[i-1];
            end
        end
    end

    // Accumulate stage: the first element of each window reloads, so no clear between runs
    always_ff @(posedge clk) begin
        if (vld_pl[RD_LAT]) begin
            acc_p <= first_pl[RD_LAT] ? f2_rdata : smax(acc_p, f2_rdata);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_wr_en <= 1'b0;
            f3_wdata <= '0;
            f3_waddr <= '0;
        end else begin
            f3_wr_en <= vld_pl[RD_LAT] && last_pl[RD_LAT];
            if (vld_pl[RD_LAT] && last_pl[RD_LAT]) begin
                f3_wdata <= smax(acc_p, f2_rdata);
                f3_waddr <= wa_pl[RD_LAT];
            end
        end
    end

endmodule

// File: tb/tb_pool1_ctrl.sv
// Scoreboard bench for pool1_ctrl: three instances (RD_LAT = 1, 2, 3) share one f2 image;
// expected writes, busy window and done cycle come from a plain 14x14 max-pool model.
module tb_pool1_ctrl;

    localparam int DW = 16;
    localparam int NI = 3;

    typedef struct {
        int     addr;
        int     data;
        longint cyc;
    } wr_t;

    typedef struct {
        int inst;
        int addr;
        int val;
    } spot_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [NI-1:0] start_v;
    logic signed [DW-1:0] f2_mem [784];
    longint        cyc = 0;

    logic [9:0]           raddr_v [NI];
    logic signed [DW-1:0] rdata_v [NI];
    logic signed [DW-1:0] wdata_v [NI];
    logic [7:0]           waddr_v [NI];
    logic                 wr_v    [NI];
    logic                 done_v  [NI];
    logic                 busy_v  [NI];

    wr_t    exp_q [NI][$];
    spot_t  spot_q[$];
    longint run_lo [NI];
    longint run_hi [NI];
    int     checks = 0;
    int     errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = g + 1;
        logic [9:0] ap [L];
        always @(posedge clk) begin
            ap[0] <= raddr_v[g];
            for (int j = 1; j < L; j++) ap[j] <= ap[j-1];
        end
        assign rdata_v[g] = f2_mem[ap[L-1]];

        pool1_ctrl #(.DW(DW), .RD_LAT(L)) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .pool1_start (start_v[g]),
            .f2_raddr    (raddr_v[g]),
            .f2_rdata    (rdata_v[g]),
            .f3_waddr    (waddr_v[g]),
            .f3_wdata    (wdata_v[g]),
            .f3_wr_en    (wr_v[g]),
            .pool1_done  (done_v[g]),
            .pool1_busy  (busy_v[g])
        );
    end

    function automatic int golden(input int n);
        int r, c, m, v;
        r = n / 14;
        c = n % 14;
        m = int'(f2_mem[(2 * r) * 28 + 2 * c]);
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
                v = int'(f2_mem[(2 * r + dy) * 28 + 2 * c + dx]);
                if (v > m) m = v;
            end
        return m;
    endfunction

    // Monitor: owns every comparison
    always @(negedge clk) begin
        logic bexp, dexp;
        wr_t  e;
        for (int i = 0; i < NI; i++) begin
            bexp = (cyc >= run_lo[i]) && (cyc <= run_hi[i]);
            dexp = (cyc == run_hi[i]);
            checks++;
            if (busy_v[i] !== bexp) begin
                errors++;
                $display("FAIL busy[%0d] cyc %0d got %0b want %0b", i, cyc, busy_v[i], bexp);
            end
            checks++;
            if (done_v[i] !== dexp) begin
                errors++;
                $display("FAIL done[%0d] cyc %0d got %0b want %0b", i, cyc, done_v[i], dexp);
            end
            if (!rst_n) begin
                checks++;
                if (raddr_v[i] !== 10'd0 || wr_v[i] !== 1'b0 || waddr_v[i] !== 8'd0 || wdata_v[i] !== '0) begin
                    errors++;
                    $display("FAIL reset_out[%0d] got raddr %0d wr %0b waddr %0d wdata %0d want all 0",
                             i, raddr_v[i], wr_v[i], waddr_v[i], wdata_v[i]);
                end
            end
            if (wr_v[i] === 1'b1) begin
                checks++;
                if (exp_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write[%0d] cyc %0d addr %0d data %0d want no write",
                             i, cyc, waddr_v[i], wdata_v[i]);
                end else begin
                    e = exp_q[i].pop_front();
                    if (int'(waddr_v[i]) != e.addr || int'(wdata_v[i]) != e.data || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL write[%0d] got addr %0d data %0d cyc %0d want addr %0d data %0d cyc %0d",
                                 i, waddr_v[i], wdata_v[i], cyc, e.addr, e.data, e.cyc);
                    end
                end
                for (int s = 0; s < spot_q.size(); s++) begin
                    if (spot_q[s].inst == i && spot_q[s].addr == int'(waddr_v[i])) begin
                        checks++;
                        if (int'(wdata_v[i]) != spot_q[s].val) begin
                            errors++;
                            $display("FAIL spot[%0d] f3[%0d] got %0d want %0d",
                                     i, spot_q[s].addr, wdata_v[i], spot_q[s].val);
                        end
                        spot_q.delete(s);
                        break;
                    end
                end
            end else if (exp_q[i].size() > 0 && cyc > exp_q[i][0].cyc) begin
                checks++;
                errors++;
                e = exp_q[i].pop_front();
                $display("FAIL missing_write[%0d] addr %0d want at cyc %0d got none", i, e.addr, e.cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_until(input longint c);
        while (cyc < c) step(1);
    endtask

    task automatic start_run(input logic [NI-1:0] mask);
        longint t0;
        wr_t    e;
        t0 = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (mask[i]) begin
                for (int n = 0; n < 196; n++) begin
                    e.addr = n;
                    e.data = golden(n);
                    e.cyc  = t0 + 4 * n + (i + 1) + 5;
                    exp_q[i].push_back(e);
                end
                run_lo[i] = t0;
                run_hi[i] = t0 + (i + 1) + 788;
            end
        end
        start_v = mask;
        step(1);
        start_v = '0;
    endtask

    task automatic wait_done();
        longint last;
        last = 0;
        for (int i = 0; i < NI; i++) if (run_hi[i] > last) last = run_hi[i];
        for (int k = 0; k < 4000; k++) begin
            if (cyc > last + 2 && exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0)
                return;
            step(1);
        end
        $display("FAIL wait_done timeout at cyc %0d", cyc);
        $fatal(1, "bench timeout");
    endtask

    task automatic fill_random(input bit narrow);
        for (int a = 0; a < 784; a++)
            f2_mem[a] = narrow ? DW'($urandom_range(0, 7)) - DW'(4) : DW'($urandom);
    endtask

    initial begin
        longint t0;
        logic [NI-1:0] mask;
        rst_n   = 1'b0;
        start_v = '0;
        for (int i = 0; i < NI; i++) begin
            run_lo[i] = 64'sd1 << 40;
            run_hi[i] = -1;
        end
        for (int a = 0; a < 784; a++) f2_mem[a] = '0;
        step(3);
        rst_n = 1'b1;
        step(2);

        // Ramp image
        for (int a = 0; a < 784; a++) f2_mem[a] = DW'(a);
        for (int i = 0; i < NI; i++) begin
            spot_q.push_back('{i, 0, 29});
            spot_q.push_back('{i, 1, 31});
            spot_q.push_back('{i, 14, 85});
            spot_q.push_back('{i, 195, 783});
        end
        start_run('1);
        wait_done();

        // Signed extremes and ties
        for (int a = 0; a < 784; a++) f2_mem[a] = -16'sd32768;
        f2_mem[10] = -16'sd5;   f2_mem[11] = -16'sd3;
        f2_mem[38] = -16'sd8;   f2_mem[39] = -16'sd100;
        f2_mem[68] = 16'sd7;    f2_mem[69] = 16'sd7;
        f2_mem[96] = 16'sd7;    f2_mem[97] = 16'sd7;
        for (int i = 0; i < NI; i++) begin
            spot_q.push_back('{i, 5, -3});
            spot_q.push_back('{i, 20, 7});
            spot_q.push_back('{i, 0, -32768});
        end
        start_run('1);
        wait_done();

        // Starts while busy are ignored; a start right after DONE begins a fresh run
        fill_random(1'b1);
        t0 = cyc + 1;
        start_run('1);
        wait_until(t0 + 100);
        start_v = '1;
        step(1);
        start_v = '0;
        wait_until(t0 + 787);
        start_v = '1;
        step(1);
        start_v = '0;
        for (longint c = t0 + 790; c <= t0 + 792; c++) begin
            wait_until(c);
            mask = '0;
            for (int i = 0; i < NI; i++) if (t0 + (i + 1) + 789 == c) mask[i] = 1'b1;
            start_run(mask);
        end
        wait_done();

        // Asynchronous reset in the middle of a run
        fill_random(1'b0);
        t0 = cyc + 1;
        start_run('1);
        wait_until(t0 + 400);
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            exp_q[i].delete();
            run_lo[i] = 64'sd1 << 40;
            run_hi[i] = -1;
        end
        step(3);
        rst_n = 1'b1;
        step(20);
        fill_random(1'b0);
        start_run('1);
        wait_done();

        // Further random passes
        for (int r = 0; r < 2; r++) begin
            fill_random(r[0]);
            start_run('1);
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
